wavegen_dds: RTL
================

// Module: wavegen_dds
// PURPOSE
//  Parametrised phase-accumulator (DDS) waveform generator; successor of the fixed 8-bit counter waveform block.
//  Emits saw, reverse saw, triangle, 50% meander, 25% meander and a programmable-duty pulse from one accumulator.
//  Adds a run/stop control, a glitch-free tuning-word update, a wave select mux and a per-period sync pulse.
//  Feeds the audio/note path: the note logic drives ftw_in, and downstream logic consumes wave_out.
// PARAMETERS
//  ACC_W  24  phase accumulator width; sets frequency resolution: f_out = f_clk*ftw/2^ACC_W
//  OUT_W  8   output sample width; phase p = acc[ACC_W-1 -: OUT_W]; requires OUT_W >= 3 and ACC_W >= OUT_W
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  run         in   1      1: accumulator advances each clk; 0: accumulator holds
//  ftw_in      in   ACC_W  frequency tuning word
//  ftw_load    in   1      1-cycle strobe; captures ftw_in
//  duty        in   OUT_W  pulse threshold
//  wave_sel    in   3      0 saw, 1 revsaw, 2 triangl, 3 meander, 4 meander025, 5 pulse, 6/7 -> 0
//  saw         out  OUT_W  ramp up
//  revsaw      out  OUT_W  ramp down
//  triangl     out  OUT_W  triangle
//  meander     out  OUT_W  50% square
//  meander025  out  OUT_W  25% square
//  pulse       out  OUT_W  duty-controlled square
//  wave_out    out  OUT_W  wave_sel-selected waveform
//  sync        out  1      1-cycle pulse aligned with the first sample of each new period
//  ftw_pending out  1      1 while a loaded word waits for a wrap
// BEHAVIOUR
//  Reset (async assert, sync release): acc=0, ftw_q=0, pend=0, ftw_pending=0, sync=0, all waveform outputs=0.
//  Accumulator: if run, acc <= (acc + ftw_q) mod 2^ACC_W; wrap = carry-out of that add; if !run, no wrap.
//  Tuning word:
//   - run=0 and ftw_load: ftw_q <= ftw_in next edge; pending stays 0.
//   - run=1 and ftw_load, no wrap: pend <= ftw_in, ftw_pending <= 1; ftw_q unchanged.
//   - wrap cycle: ftw_q <= ftw_load ? ftw_in : (ftw_pending ? pend : ftw_q); ftw_pending <= 0.
//   - A newer load overwrites pend (last wins).
//   - New ftw_q is used for the add one cycle after the wrap.
//  Shaping, from p = current acc MSBs, MAX = all ones:
//   - saw = p
//   - revsaw = ~p
//   - triangl = p[MSB] ? ~{p[OUT_W-2:0],0} : {p[OUT_W-2:0],0}
//   - meander = p < 2^(OUT_W-1) ? MAX : 0
//   - meander025 = p < 2^(OUT_W-2) ? MAX : 0
//   - pulse = p < duty ? MAX : 0; duty=0 gives constant 0
//  Latency: all waveform outputs, wave_out and sync are registered.
//   - Each reflects acc with exactly 1 cycle of latency; sync is the registered wrap.
//  wave_sel and duty are sampled combinationally into the output register.
//   - A change shows on the next edge, with no period alignment.
//  run=0: outputs hold the steady shaping of the frozen acc; sync=0.
//  ftw_q=0 with run=1: acc frozen; no sync.
//  Reset mid-operation: everything returns to reset values immediately, and any pending word is discarded.
// STRUCTURE
//  wavegen_pkg: wave_sel encodings (WS_SAW..WS_PULSE) as localparams/typedef.
//  Sub-module wave_shaper: combinational; p, duty -> six waveforms.
//  Top: accumulator, tuning-word/pending logic, output and sync registers.
// TESTING (ACC_W=8, OUT_W=8 unless stated)
//  1. Reset low, then high, run=0, ftw_q=0:
//     all outputs 0 during reset; after the first edge saw=0, revsaw=255, triangl=0, meander=255, meander025=255, pulse=0.
//  2. run=0, load ftw=1, then run=1:
//     saw steps 0,1..255,0; triangl=254 at saw=127 and 255 at saw=128; sync once per 256 cycles, coincident with saw=0.
//  3. Running at ftw=1, load ftw=4 at saw=10:
//     ftw_pending=1 and steps stay 1 until the wrap; then saw 0,4,8..; ftw_pending=0.
//  4. wave_sel=5, duty=64, ftw=1:
//     wave_out=255 for 64 cycles, then 0 for 192 cycles per period; duty=0 gives constant 0.
//  5. ftw_load coincident with a wrap:
//     the new word is used immediately after the wrap, with no one-period delay; a second load before a wrap overwrites pend.
//  6. Assert reset mid-period at saw=77:
//     outputs=0 asynchronously; after release the ramp restarts from 0 with ftw_q=0 (static) until reloaded.
//  7. ACC_W=24, ftw=2^16:
//     sync period = 256 cycles, and saw increments by 1 each cycle.

Source files
------------

// File: rtl/wavegen_pkg.sv
// rtl/wavegen_pkg.sv - shared encodings for the DDS waveform generator
package wavegen_pkg;

    typedef enum logic [2:0] {
        WS_SAW        = 3'd0,
        WS_REVSAW     = 3'd1,
        WS_TRIANGL    = 3'd2,
        WS_MEANDER    = 3'd3,
        WS_MEANDER025 = 3'd4,
        WS_PULSE      = 3'd5
    } wave_sel_t;

endpackage

// File: rtl/wave_shaper.sv
// rtl/wave_shaper.sv - combinational phase-to-waveform shaping
module wave_shaper
    import wavegen_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [OUT_W-1:0] p,
    input  logic [OUT_W-1:0] duty,
    output logic [OUT_W-1:0] saw,
    output logic [OUT_W-1:0] revsaw,
    output logic [OUT_W-1:0] triangl,
    output logic [OUT_W-1:0] meander,
    output logic [OUT_W-1:0] meander025,
    output logic [OUT_W-1:0] pulse
);

    localparam logic [OUT_W-1:0] MAX     = '1;
    localparam logic [OUT_W-1:0] HALF    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] QUARTER = {2'b01, {(OUT_W-2){1'b0}}};

    logic [OUT_W-1:0] dbl;

    // Triangle folds the doubled phase on the second half of the period
    assign dbl        = {p[OUT_W-2:0], 1'b0};
    assign saw        = p;
    assign revsaw     = ~p;
    assign triangl    = p[OUT_W-1] ? ~dbl : dbl;
    assign meander    = (p < HALF)    ? MAX : '0;
    assign meander025 = (p < QUARTER) ? MAX : '0;
    assign pulse      = (p < duty)    ? MAX : '0;

endmodule

// File: rtl/wavegen_dds.sv
// rtl/wavegen_dds.sv - phase-accumulator waveform generator with glitch-free tuning
module wavegen_dds
    import wavegen_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [ACC_W-1:0] ftw_in,
    input  logic             ftw_load,
    input  logic [OUT_W-1:0] duty,
    input  logic [2:0]       wave_sel,
    output logic [OUT_W-1:0] saw,
    output logic [OUT_W-1:0] revsaw,
    output logic [OUT_W-1:0] triangl,
    output logic [OUT_W-1:0] meander,
    output logic [OUT_W-1:0] meander025,
    output logic [OUT_W-1:0] pulse,
    output logic [OUT_W-1:0] wave_out,
    output logic             sync,
    output logic             ftw_pending
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ftw_q;
    logic [ACC_W-1:0] pend;
    logic [ACC_W:0]   sum;
    logic             wrap;
    logic             wrap_q;
    logic [OUT_W-1:0] p;
    logic [OUT_W-1:0] sh_saw, sh_revsaw, sh_triangl, sh_meander, sh_meander025, sh_pulse;
    logic [OUT_W-1:0] sel_wave;

    assign sum  = {1'b0, acc} + {1'b0, ftw_q};
    assign wrap = run & sum[ACC_W];
    assign p    = acc[ACC_W-1 -: OUT_W];

    wave_shaper #(.OUT_W(OUT_W)) u_shaper (
        .p          (p),
        .duty       (duty),
        .saw        (sh_saw),
        .revsaw     (sh_revsaw),
        .triangl    (sh_triangl),
        .meander    (sh_meander),
        .meander025 (sh_meander025),
        .pulse      (sh_pulse)
    );

    always_comb begin
        sel_wave = sh_saw;
        case (wave_sel)
            WS_REVSAW:     sel_wave = sh_revsaw;
            WS_TRIANGL:    sel_wave = sh_triangl;
            WS_MEANDER:    sel_wave = sh_meander;
            WS_MEANDER025: sel_wave = sh_meander025;
            WS_PULSE:      sel_wave = sh_pulse;
            default:       sel_wave = sh_saw;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc         <= '0;
            ftw_q       <= '0;
            pend        <= '0;
            ftw_pending <= 1'b0;
            wrap_q      <= 1'b0;
            sync        <= 1'b0;
            saw         <= '0;
            revsaw      <= '0;
            triangl     <= '0;
            meander     <= '0;
            meander025  <= '0;
            pulse       <= '0;
            wave_out    <= '0;
        end else begin
            if (run) begin
                acc <= sum[ACC_W-1:0];
            end

            // A new word only takes over at a wrap while running, so no period is ever cut short
            if (wrap) begin
                ftw_q       <= ftw_load ? ftw_in : (ftw_pending ? pend : ftw_q);
                ftw_pending <= 1'b0;
            end else if (ftw_load) begin
                if (run) begin
                    pend        <= ftw_in;
                    ftw_pending <= 1'b1;
                end else begin
                    ftw_q       <= ftw_in;
                    ftw_pending <= 1'b0;
                end
            end

            // sync lines up with the first output sample taken after acc wrapped
            wrap_q     <= wrap;
            sync       <= wrap_q;
            saw        <= sh_saw;
            revsaw     <= sh_revsaw;
            triangl    <= sh_triangl;
            meander    <= sh_meander;
            meander025 <= sh_meander025;
            pulse      <= sh_pulse;
            wave_out   <= sel_wave;
        end
    end

endmodule
